// File: rtl/down_timer_if.sv
// Control and status bundle for down_timer: the master drives commands and
// the timer (slave) drives count and status back.
interface down_timer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             enable;
    logic             periodic;
    logic [WIDTH-1:0] count;
    logic             zero_reached;
    logic             underflow;
    logic             busy;
    logic             done;

    modport master (
        output load, load_value, start, stop, enable, periodic,
        input  count, zero_reached, underflow, busy, done
    );

    modport slave (
        input  load, load_value, start, stop, enable, periodic,
        output count, zero_reached, underflow, busy, done
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot and periodic (auto-reload) modes.
// Per edge: reset > load > stop > start > enable-driven counting.
module down_timer #(
    parameter int unsigned       WIDTH          = 8,
    parameter logic [WIDTH-1:0]  DEFAULT_RELOAD = 8'hFF
) (
    input  logic         clk,
    input  logic         reset,
    down_timer_if.slave  tmr
);

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             underflow_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            reload_q    <= DEFAULT_RELOAD;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            underflow_q <= 1'b0;
            if (tmr.load) begin
                reload_q <= tmr.load_value;
                count_q  <= tmr.load_value;
                state_q  <= StIdle;
                done_q   <= 1'b0;
            end else if (tmr.stop) begin
                // stop also masks a same-cycle start, so non-RUN states hold
                if (state_q == StRun) begin
                    state_q <= StPaused;
                end
            end else if (tmr.start && (state_q != StRun)) begin
                if (state_q == StDone) begin
                    count_q <= reload_q;
                    done_q  <= 1'b0;
                end
                state_q <= StRun;
            end else if ((state_q == StRun) && tmr.enable) begin
                if (count_q != '0) begin
                    count_q <= count_q - 1'b1;
                end else begin
                    underflow_q <= 1'b1;
                    if (tmr.periodic) begin
                        count_q <= reload_q;
                    end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign tmr.count        = count_q;
    assign tmr.zero_reached = (count_q == '0);
    assign tmr.underflow    = underflow_q;
    assign tmr.busy         = (state_q == StRun);
    assign tmr.done         = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: one task per scenario, inline comparisons.
module tb_down_timer;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    down_timer_if #(.WIDTH(8)) bus ();

    down_timer #(
        .WIDTH          (8),
        .DEFAULT_RELOAD (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.load       = 1'b0;
        bus.load_value = 8'd0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.enable     = 1'b0;
        bus.periodic   = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load = 1'b1;
        bus.load_value = v;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (bus.count !== 8'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", bus.count);
        end
        checks++;
        if (bus.zero_reached !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0
            || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: zr=%b busy=%b done=%b uf=%b want 1 0 0 0",
                     bus.zero_reached, bus.busy, bus.done, bus.underflow);
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] exp_c [3] = '{8'd2, 8'd1, 8'd0};
        do_load(8'd3);
        checks++;
        if (bus.count !== 8'd3 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL os_load: count=%0d busy=%b want 3 0", bus.count, bus.busy);
        end
        bus.enable = 1'b1;
        do_start();
        checks++;
        if (bus.count !== 8'd3 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL os_start: count=%0d busy=%b want 3 1", bus.count, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.count !== exp_c[i] || bus.underflow !== 1'b0) begin
                errors++;
                $display("FAIL os_count[%0d]: count=%0d uf=%b want %0d 0",
                         i, bus.count, bus.underflow, exp_c[i]);
            end
        end
        checks++;
        if (bus.zero_reached !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL os_zero: zr=%b done=%b want 1 0", bus.zero_reached, bus.done);
        end
        step();
        checks++;
        if (bus.underflow !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0
            || bus.count !== 8'd0) begin
            errors++;
            $display("FAIL os_underflow: uf=%b done=%b busy=%b count=%0d want 1 1 0 0",
                     bus.underflow, bus.done, bus.busy, bus.count);
        end
        step();
        checks++;
        if (bus.underflow !== 1'b0 || bus.done !== 1'b1 || bus.count !== 8'd0) begin
            errors++;
            $display("FAIL os_hold: uf=%b done=%b count=%0d want 0 1 0",
                     bus.underflow, bus.done, bus.count);
        end
        clear_inputs();
    endtask

    task automatic test_periodic();
        logic [7:0] exp_c  [7] = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1};
        logic       exp_uf [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.periodic = 1'b1;
        do_load(8'd2);
        do_start();
        bus.enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (bus.count !== exp_c[i] || bus.underflow !== exp_uf[i] || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL per[%0d]: count=%0d uf=%b busy=%b want %0d %b 1",
                         i, bus.count, bus.underflow, bus.busy, exp_c[i], exp_uf[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reload_zero();
        bus.periodic = 1'b1;
        do_load(8'd0);
        do_start();
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.underflow !== 1'b1 || bus.count !== 8'd0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL rz[%0d]: uf=%b count=%0d busy=%b want 1 0 1",
                         i, bus.underflow, bus.count, bus.busy);
            end
        end
        clear_inputs();
    endtask

    task automatic test_pause();
        logic [7:0] exp_c [3] = '{8'd2, 8'd1, 8'd0};
        do_load(8'd5);
        do_start();
        bus.enable = 1'b1;
        step();
        step();
        checks++;
        if (bus.count !== 8'd3) begin
            errors++; $display("FAIL pause_pre: count=%0d want 3", bus.count);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        checks++;
        if (bus.count !== 8'd3 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL pause_stop: count=%0d busy=%b want 3 0", bus.count, bus.busy);
        end
        repeat (4) step();
        checks++;
        if (bus.count !== 8'd3 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL pause_hold: count=%0d busy=%b want 3 0", bus.count, bus.busy);
        end
        do_start();
        checks++;
        if (bus.count !== 8'd3 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: count=%0d busy=%b want 3 1", bus.count, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.count !== exp_c[i]) begin
                errors++;
                $display("FAIL pause_count[%0d]: count=%0d want %0d", i, bus.count, exp_c[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_load_override();
        do_load(8'd8);
        do_start();
        bus.enable = 1'b1;
        repeat (4) step();
        checks++;
        if (bus.count !== 8'd4 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL ld_pre: count=%0d busy=%b want 4 1", bus.count, bus.busy);
        end
        bus.load = 1'b1;
        bus.load_value = 8'd9;
        bus.start = 1'b1;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.count !== 8'd9 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL ld_override: count=%0d busy=%b done=%b want 9 0 0",
                     bus.count, bus.busy, bus.done);
        end
        bus.stop = 1'b1;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.count !== 8'd9) begin
            errors++;
            $display("FAIL start_stop_idle: busy=%b count=%0d want 0 9", bus.busy, bus.count);
        end
        clear_inputs();
    endtask

    task automatic test_done_restart_and_reset();
        do_load(8'd4);
        do_start();
        bus.enable = 1'b1;
        repeat (5) step();
        bus.enable = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.count !== 8'd0) begin
            errors++; $display("FAIL dr_done: done=%b count=%0d want 1 0", bus.done, bus.count);
        end
        do_start();
        checks++;
        if (bus.count !== 8'd4 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL dr_restart: count=%0d done=%b busy=%b want 4 0 1",
                     bus.count, bus.done, bus.busy);
        end
        bus.enable = 1'b1;
        step();
        checks++;
        if (bus.count !== 8'd3) begin
            errors++; $display("FAIL dr_dec: count=%0d want 3", bus.count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0
            || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d busy=%b done=%b uf=%b want 0 0 0 0",
                     bus.count, bus.busy, bus.done, bus.underflow);
        end
        bus.enable = 1'b0;
        do_start();
        bus.enable = 1'b1;
        step();
        bus.enable = 1'b0;
        checks++;
        if (bus.underflow !== 1'b1 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL rst_underflow: uf=%b done=%b want 1 1", bus.underflow, bus.done);
        end
        // Restart from DONE exposes the reload register, which reset restored.
        do_start();
        checks++;
        if (bus.count !== 8'hFF || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_reload: count=%0h busy=%b want ff 1", bus.count, bus.busy);
        end
        clear_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        clear_inputs();
        test_reset();
        test_one_shot();
        test_periodic();
        test_reload_zero();
        test_pause();
        test_load_override();
        test_done_restart_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
